vga_sync_receiver: RTL and testbench

Receive-side counterpart of the game's VGA output: consumes the pixel-enable strobe, active-low hor/ver sync and 8-bit RGB exactly as the video path drives them, and recovers pixel coordinates. Validates line and frame timing and locks after consecutive clean frames. Emits a per-pixel valid/coordinate/colour stream for frame capture and self-checking of the display path on the system clock.

---
 rtl/vga_sync_receiver.sv | 175 +++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers pixel coordinates from pixel strobe and syncs,
// checks line/frame timing and locks after consecutive clean frames.
module vga_sync_receiver #(
  parameter int H_ACTIVE    = 640,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_FP        = 16,
  parameter int V_ACTIVE    = 480,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_FP        = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_clk,
  input  logic        hor_sync,
  input  logic        ver_sync,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic [7:0]  err_count
);

  localparam int H_TOTAL = H_ACTIVE + H_SYNC + H_BP + H_FP;
  localparam int V_TOTAL = V_ACTIVE + V_SYNC + V_BP + V_FP;
  localparam int GW      = $clog2(LOCK_FRAMES + 1);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_LO   = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_HI   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_LO   = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_HI   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [GW-1:0] G_LOCK = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic          h_prev;
  logic          v_prev;
  logic          arm;
  logic          arm_nx;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic [9:0]    h_nx;
  logic [9:0]    v_nx;
  logic [GW-1:0] good;
  logic [GW-1:0] good_nx;
  logic [GW-1:0] good_inc;
  logic [7:0]    err_nx;
  logic          hfall;
  logic          vfall;
  logic          fs;
  logic          line_err;
  logic          frame_err;
  logic          err;
  logic          pix_hit;

  // Checks use the counts before this sample; coordinates use the new counts.
  always_comb begin
    hfall     = h_prev & ~hor_sync;
    vfall     = v_prev & ~ver_sync;
    fs        = hfall & ~ver_sync & (arm | vfall);
    line_err  = hfall ? (h_cnt != H_LAST) : (h_cnt == H_LAST);
    frame_err = fs ? (v_cnt != V_LAST)
                   : (hfall & (v_cnt == V_LAST));
    err       = vga_clk & (state != SEARCH)
                & (line_err | frame_err);
    h_nx      = hfall ? '0
              : (h_cnt == H_LAST) ? h_cnt
              : h_cnt + 10'd1;
    v_nx      = fs ? '0
              : (hfall && v_cnt != V_LAST) ? v_cnt + 10'd1
              : v_cnt;
    arm_nx    = fs ? 1'b0
              : (vfall & ~hfall) ? 1'b1
              : arm;
    good_inc  = good + GW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEARCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (vga_clk) begin
      unique case (state)
        SEARCH: begin
          if (fs) state_nx = ACQUIRE;
        end
        ACQUIRE: begin
          if (err)
            state_nx = SEARCH;
          else if (fs && good_inc == G_LOCK)
            state_nx = LOCKED;
        end
        LOCKED: begin
          if (err) state_nx = SEARCH;
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  always_comb begin
    good_nx = good;
    err_nx  = err_count;
    pix_hit = 1'b0;
    if (vga_clk) begin
      if (state == SEARCH && fs)
        good_nx = '0;
      else if (state == ACQUIRE && fs && !err)
        good_nx = good_inc;
      if (err && err_count != 8'hFF)
        err_nx = err_count + 8'd1;
      pix_hit = (state == LOCKED)
              && h_nx >= H_LO && h_nx <= H_HI
              && v_nx >= V_LO && v_nx <= V_HI;
    end
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_prev      <= 1'b0;
      v_prev      <= 1'b0;
      arm         <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      good        <= '0;
      err_count   <= '0;
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
    end else begin
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      if (vga_clk) begin
        h_prev      <= hor_sync;
        v_prev      <= ver_sync;
        arm         <= arm_nx;
        h_cnt       <= h_nx;
        v_cnt       <= v_nx;
        good        <= good_nx;
        err_count   <= err_nx;
        frame_start <= fs;
        pix_valid   <= pix_hit;
        if (pix_hit) begin
          pix_x   <= h_nx - H_LO;
          pix_y   <= v_nx - V_LO;
          pix_rgb <= {red, green, blue};
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Scoreboard bench for vga_sync_receiver on a reduced timing so
// whole frames, relocks and error saturation fit in a short run.
module tb_vga_sync_receiver;

  localparam int HA = 16;
  localparam int HS = 4;
  localparam int HB = 3;
  localparam int HF = 2;
  localparam int VA = 6;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VF = 2;
  localparam int HT  = HA + HS + HB + HF;
  localparam int VT  = VA + VS + VB + VF;
  localparam int HLO = HS + HB;
  localparam int HHI = HLO + HA - 1;
  localparam int VLO = VS + VB;
  localparam int VHI = VLO + VA - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vga_clk = 1'b0;
  logic        hor_sync = 1'b1;
  logic        ver_sync = 1'b1;
  logic [7:0]  red = '0;
  logic [7:0]  green = '0;
  logic [7:0]  blue = '0;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [23:0] pix_rgb;
  logic        frame_start;
  logic        locked;
  logic [7:0]  err_count;

  int n_chk   = 0;
  int n_fail  = 0;
  int fs_seen = 0;
  int fs_exp  = 0;
  int pv_seen = 0;
  int err_exp = 0;
  int cyc     = 0;
  int p0;
  logic [59:0] sb[$];

  vga_sync_receiver #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_FP(HF),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_FP(VF),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga_clk(vga_clk),
    .hor_sync(hor_sync),
    .ver_sync(ver_sync),
    .red(red),
    .green(green),
    .blue(blue),
    .pix_valid(pix_valid),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .pix_rgb(pix_rgb),
    .frame_start(frame_start),
    .locked(locked),
    .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Each expected pixel carries the clk count at which it must appear.
  always @(negedge clk) begin
    if (frame_start) fs_seen++;
    if (pix_valid) begin
      pv_seen++;
      if (sb.size() == 0)
        chk("pix_unexp", 64'(pix_valid), 64'd0);
      else
        chk("pix", {4'd0, cyc[15:0], pix_x, pix_y, pix_rgb},
            {4'd0, sb.pop_front()});
    end
  end

  task automatic smp(input logic hs, input logic vs,
                     input logic [23:0] rgb, input bit act,
                     input int x, input int y);
    @(negedge clk);
    vga_clk  = 1'b1;
    hor_sync = hs;
    ver_sync = vs;
    {red, green, blue} = rgb;
    if (act) sb.push_back({16'(cyc + 1), 10'(x), 10'(y), rgb});
    @(negedge clk);
    vga_clk = 1'b0;
  endtask

  task automatic idle();
    repeat (3) smp(1'b1, 1'b1, 24'd0, 1'b0, 0, 0);
  endtask

  task automatic pulse_rst();
    chk("pre_rst_pv", 64'(pix_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_lock", 64'(locked), 64'd0);
    chk("rst_pv", 64'(pix_valid), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    chk("rst_fs", 64'(frame_start), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    err_exp = 0;
  endtask

  task automatic frame(input int lines, input int bad_line,
                       input int bad_len, input bit early,
                       input bit lk, input bit pix, input int rst_v);
    bit on;
    bit act;
    int len;
    int ev;
    int eh;
    logic hs;
    logic vs;
    logic [23:0] rgb;
    on = pix;
    ev = -1;
    eh = -1;
    if (bad_line >= 0 && bad_len > HT) begin
      ev = bad_line; eh = HT;
    end else if (bad_line >= 0 && bad_len < HT) begin
      ev = bad_line + 1; eh = 0;
    end else if (lines > VT) begin
      ev = VT; eh = 0;
    end
    for (int v = 0; v < lines; v++) begin
      len = (v == bad_line) ? bad_len : HT;
      for (int h = 0; h < len; h++) begin
        hs = (h >= HS);
        vs = (v >= VS);
        if (early && v == lines - 1 && h == len - 1) vs = 1'b0;
        rgb = (h == HLO && v == VLO) ? 24'h123456
                                     : 24'($urandom);
        act = on && h >= HLO && h <= HHI
                 && v >= VLO && v <= VHI;
        smp(hs, vs, rgb, act, h - HLO, v - VLO);
        if (v == 0 && h == 0) begin
          fs_exp++;
          chk("fs_pulse", 64'(frame_start), 64'd1);
          chk("lock_at_fs", 64'(locked), 64'(lk));
        end
        if (v == ev && h == eh) begin
          on = 1'b0;
          if (err_exp < 255) err_exp++;
          chk("err_inc", 64'(err_count), 64'(err_exp));
          chk("lock_drop", 64'(locked), 64'd0);
        end
        if (v == rst_v && h == HLO) begin
          pulse_rst();
          return;
        end
      end
    end
  endtask

  task automatic clean(input bit lk, input bit pix);
    frame(VT, -1, HT, 1'b0, lk, pix, -1);
  endtask

  task automatic relock();
    clean(1'b0, 1'b0);
    clean(1'b0, 1'b0);
    clean(1'b1, 1'b1);
  endtask

  task automatic end_chk(input bit lk);
    chk("lock", 64'(locked), 64'(lk));
    chk("err_cnt", 64'(err_count), 64'(err_exp));
    chk("fs_cnt", 64'(fs_seen), 64'(fs_exp));
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  // Each burst step enters ACQUIRE via a frame start, then cuts the line short.
  task automatic burst(input int n);
    for (int i = 0; i < n; i++) begin
      smp(1'b1, 1'b1, 24'd0, 1'b0, 0, 0);
      smp(1'b1, 1'b1, 24'd0, 1'b0, 0, 0);
      smp(1'b0, 1'b0, 24'd0, 1'b0, 0, 0);
      fs_exp++;
      smp(1'b0, 1'b0, 24'd0, 1'b0, 0, 0);
      smp(1'b1, 1'b0, 24'd0, 1'b0, 0, 0);
      smp(1'b1, 1'b0, 24'd0, 1'b0, 0, 0);
      smp(1'b0, 1'b0, 24'd0, 1'b0, 0, 0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    #1;
    chk("rst_lock0", 64'(locked), 64'd0);
    chk("rst_err0", 64'(err_count), 64'd0);
    chk("rst_pv0", 64'(pix_valid), 64'd0);
    chk("rst_fs0", 64'(frame_start), 64'd0);
    chk("rst_xy0", {34'd0, pix_x, pix_y}, 64'd0);
    chk("rst_rgb0", 64'(pix_rgb), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();

    relock();
    end_chk(1'b1);

    p0 = pv_seen;
    frame(VT, -1, HT, 1'b1, 1'b1, 1'b1, -1);
    chk("pix_count", 64'(pv_seen - p0), 64'(HA * VA));
    end_chk(1'b1);

    frame(VT, VLO + 1, HT + 1, 1'b0, 1'b1, 1'b1, -1);
    end_chk(1'b0);
    relock();
    end_chk(1'b1);

    frame(VT, VLO + 1, HT - 1, 1'b0, 1'b1, 1'b1, -1);
    end_chk(1'b0);
    relock();
    end_chk(1'b1);

    frame(VT + 1, -1, HT, 1'b0, 1'b1, 1'b1, -1);
    end_chk(1'b0);
    relock();
    end_chk(1'b1);

    burst(100);
    err_exp = err_exp + 101;
    chk("err_mid", 64'(err_count), 64'(err_exp));
    burst(200);
    err_exp = 255;
    chk("err_sat", 64'(err_count), 64'd255);
    end_chk(1'b0);

    idle();
    relock();
    end_chk(1'b1);

    frame(VT, -1, HT, 1'b0, 1'b1, 1'b1, VLO + 1);
    idle();
    relock();
    end_chk(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
